// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants used by the fetch queue.
package riscv_pkg;
    localparam int          DEFAULT_XLEN     = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO holding {pc, instruction} pairs for the fetch queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Flush empties the queue at the next edge and wins over read and write.
module fetch_queue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers; a flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and decode.
// Keeps up to MAX_OUT requests in flight and only issues when every kept
// response is guaranteed a queue slot. A redirect flushes the queue and
// marks all in-flight responses for dropping.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
// arrives into an empty queue is presented to decode in the same cycle.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int               XLEN     = DEFAULT_XLEN,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     im_req,
    output logic [XLEN-1:0]          im_addr,
    input  logic                     im_valid,
    input  logic [XLEN-1:0]          im_data,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_addr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [XLEN-1:0]          instr,
    output logic [XLEN-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    // level + outstanding can reach 2*DEPTH, so one bit wider than level.
    localparam int SW = LW + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [SW-1:0]     committed;
    logic              keep;
    logic              wr_en;
    logic              rd_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;

    // Slots already spoken for: queued entries plus responses we will keep.
    assign committed = SW'(level) + SW'(outstanding) - SW'(drop_cnt);

    // rst gating keeps the request low while reset is held.
    assign im_req  = !rst && !redirect && (outstanding < OW'(MAX_OUT))
                     && (committed < SW'(DEPTH));
    assign im_addr = fetch_pc;

    assign keep = im_valid && (drop_cnt == '0) && !redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = fifo_empty && keep;
    assign instr_valid = !fifo_empty || bypass;
    assign instr       = bypass ? im_data : head[XLEN-1:0];
    assign instr_pc    = bypass ? resp_pc : head[2*XLEN-1:XLEN];
    assign wr_en       = keep && !(bypass && instr_ready);
`else
    assign instr_valid = !fifo_empty;
    assign instr       = head[XLEN-1:0];
    assign instr_pc    = head[2*XLEN-1:XLEN];
    assign wr_en       = keep;
`endif

    assign rd_en = !fifo_empty && instr_ready;

    fetch_queue_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect),
        .wr_en   (wr_en),
        .wr_data ({resp_pc, im_data}),
        .rd_en   (rd_en),
        .rd_data (head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_addr;
        end else if (im_req) begin
            fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        end
    end

    // PC attached to the next response that will be kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_pc <= RESET_PC;
        end else if (redirect) begin
            resp_pc <= redirect_addr;
        end else if (keep) begin
            resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
        end
    end

    // In-flight request count; redirect never issues so it needs no special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + OW'(im_req) - OW'(im_valid);
        end
    end

    // Responses still to discard; a redirect re-arms it from what remains in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= outstanding - OW'(im_valid);
        end else if (im_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - OW'(1);
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        im_valid |-> (outstanding != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && fifo_full && !rd_en));
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table, directed
// redirect/reset sequences, a latency-3 single-outstanding instance and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        im_req, im_valid, redirect, instr_valid, instr_ready;
    logic [31:0] im_addr, im_data, redirect_addr, instr, instr_pc;
    logic [2:0]  level;

    logic        rst1;
    logic        im_req1, im_valid1, redirect1, instr_valid1, instr_ready1;
    logic [31:0] im_addr1, im_data1, redirect_addr1, instr1, instr_pc1;
    logic [2:0]  level1;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr),
        .im_valid(im_valid), .im_data(im_data), .redirect(redirect),
        .redirect_addr(redirect_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .level(level));

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(1), .RESET_PC(32'h0)) dut1 (
        .clk(clk), .rst(rst1), .im_req(im_req1), .im_addr(im_addr1),
        .im_valid(im_valid1), .im_data(im_data1), .redirect(redirect1),
        .redirect_addr(redirect_addr1), .instr_valid(instr_valid1),
        .instr_ready(instr_ready1), .instr(instr1), .instr_pc(instr_pc1), .level(level1));

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          dropped;
    } req_t;

    typedef struct {
        bit          rdy;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_level;
    } vec_t;

    // Reference model: memory requests in flight and kept PCs in the queue.
    req_t        inflight[$];
    logic [31:0] q[$];
    logic [31:0] exp_fetch;
    int          cyc;
    int          lat;
    bit          rand_lat;
    int          checks;
    int          failures;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive inputs, sample and compare, then advance the model past the edge.
    task automatic step(input bit rdy, input bit rdr, input logic [31:0] raddr);
        bit          resp_now;
        bit          exp_req;
        bit          exp_valid;
        bit          bypass;
        int          kept;
        int          l;
        logic [31:0] exp_pc;
        req_t        r;
        @(negedge clk);
        instr_ready   = rdy;
        redirect      = rdr;
        redirect_addr = raddr;
        resp_now      = (inflight.size() > 0) && (inflight[0].due <= cyc);
        im_valid      = resp_now;
        im_data       = resp_now ? word_of(inflight[0].addr) : $urandom;
        #1;
        kept = 0;
        foreach (inflight[i]) if (!inflight[i].dropped) kept++;
        exp_req = !rdr && (inflight.size() < MAX_OUT) && ((q.size() + kept) < DEPTH);
        check("im_req", 32'(im_req), 32'(exp_req));
        if (exp_req) check("im_addr", im_addr, exp_fetch);
        bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass = (q.size() == 0) && resp_now && !inflight[0].dropped && !rdr;
`endif
        exp_valid = (q.size() > 0) || bypass;
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            exp_pc = (q.size() > 0) ? q[0] : inflight[0].addr;
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, word_of(exp_pc));
        end
        check("level", 32'(level), 32'(q.size()));
        if (exp_valid && rdy && (q.size() > 0)) void'(q.pop_front());
        if (resp_now) begin
            r = inflight.pop_front();
            if (!r.dropped && !rdr && !(bypass && rdy)) q.push_back(r.addr);
        end
        if (rdr) begin
            q.delete();
            foreach (inflight[i]) inflight[i].dropped = 1'b1;
            exp_fetch = raddr;
        end
        if (exp_req) begin
            l = rand_lat ? int'($urandom_range(1, 4)) : lat;
            r.addr = exp_fetch;
            r.due = cyc + l;
            r.dropped = 1'b0;
            inflight.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
        end
        cyc++;
    endtask

    task automatic wait_valid(input string name, output logic [31:0] pc);
        bit found;
        found = 1'b0;
        pc = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (instr_valid) begin
                found = 1'b1;
                pc = instr_pc;
            end
        end
        check({name, "_found"}, 32'(found), 32'd1);
    endtask

    // Hold redirect long enough for every in-flight response to return.
    task automatic drain_redirect(input logic [31:0] a);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, a);
    endtask

    task automatic reach_l2_o2(input string name);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (q.size() == 2 && inflight.size() == 2) reached = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        check(name, 32'(reached), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[21];
        req_t        p1[$];
        req_t        r1;
        logic [31:0] pc;
        logic [31:0] exp_a1;
        logic [31:0] exp_pc1;
        int          last_req;
        int          n_req;
        int          n_instr;
        bit          reached;
        bit          rdr;
        logic [31:0] ra;

        // Latency 1, DEPTH 4, MAX_OUT 2: fill, steady stream, 10-cycle stall, release.
        vecs[0]  = '{1, 1, 32'd0,  0, 32'd0,  3'd0};
        vecs[1]  = '{1, 1, 32'd4,  0, 32'd0,  3'd0};
        vecs[2]  = '{1, 1, 32'd8,  1, 32'd0,  3'd1};
        vecs[3]  = '{1, 1, 32'd12, 1, 32'd4,  3'd1};
        vecs[4]  = '{1, 1, 32'd16, 1, 32'd8,  3'd1};
        vecs[5]  = '{1, 1, 32'd20, 1, 32'd12, 3'd1};
        vecs[6]  = '{0, 1, 32'd24, 1, 32'd16, 3'd1};
        vecs[7]  = '{0, 1, 32'd28, 1, 32'd16, 3'd2};
        vecs[8]  = '{0, 0, 32'd0,  1, 32'd16, 3'd3};
        for (int i = 9; i <= 15; i++) vecs[i] = '{0, 0, 32'd0, 1, 32'd16, 3'd4};
        vecs[16] = '{1, 0, 32'd0,  1, 32'd16, 3'd4};
        vecs[17] = '{1, 1, 32'd32, 1, 32'd20, 3'd3};
        vecs[18] = '{1, 1, 32'd36, 1, 32'd24, 3'd2};
        vecs[19] = '{1, 1, 32'd40, 1, 32'd28, 3'd2};
        vecs[20] = '{1, 1, 32'd44, 1, 32'd32, 3'd2};

        checks = 0; failures = 0; cyc = 0; lat = 1; rand_lat = 1'b0;
        exp_fetch = 32'h0;
        rst = 1'b1; im_valid = 1'b0; im_data = '0; redirect = 1'b0;
        redirect_addr = '0; instr_ready = 1'b0;
        rst1 = 1'b1; im_valid1 = 1'b0; im_data1 = '0; redirect1 = 1'b0;
        redirect_addr1 = '0; instr_ready1 = 1'b1;

        #1;
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);

        // MAX_OUT=1 instance with memory latency 3.
        @(posedge clk); #1 rst1 = 1'b0;
        exp_a1 = 32'h0; exp_pc1 = 32'h0; last_req = -1; n_req = 0; n_instr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (p1.size() > 0 && p1[0].due <= c) begin
                im_valid1 = 1'b1;
                im_data1  = word_of(p1[0].addr);
            end else begin
                im_valid1 = 1'b0;
                im_data1  = '0;
            end
            #1;
            if (instr_valid1) begin
                check("lat3_pc", instr_pc1, exp_pc1);
                check("lat3_instr", instr1, word_of(exp_pc1));
                exp_pc1 = exp_pc1 + 32'd4;
                n_instr++;
            end
            if (im_valid1) void'(p1.pop_front());
            if (im_req1) begin
                if (last_req >= 0) check("lat3_spacing", 32'((c - last_req) >= 3), 32'd1);
                check("lat3_addr", im_addr1, exp_a1);
                r1.addr = exp_a1; r1.due = c + 3; r1.dropped = 1'b0;
                p1.push_back(r1);
                exp_a1 = exp_a1 + 32'd4;
                last_req = c;
                n_req++;
            end
        end
        im_valid1 = 1'b0;
        check("lat3_req_count", 32'(n_req), 32'd10);
        check("lat3_instr_count", 32'(n_instr), 32'd9);

        // Directed vector table on the main instance.
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rdy, 1'b0, 32'h0);
            check($sformatf("vec%0d_req", i), 32'(im_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), im_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
        end

        // Redirect with two requests in flight and entries queued.
        lat = 3;
        drain_redirect(32'h0000_0050);
        reach_l2_o2("redir_setup");
        step(1'b0, 1'b1, 32'h0000_0100);
        lat = 1;
        step(1'b0, 1'b0, 32'h0);
        check("redir_level", 32'(level), 32'd0);
        wait_valid("redir_first", pc);
        check("redir_first_pc", pc, 32'h0000_0100);
        wait_valid("redir_second", pc);
        check("redir_second_pc", pc, 32'h0000_0104);

        // Redirect in the same cycle a response returns with one outstanding.
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (inflight.size() == 1 && inflight[0].due <= cyc && !inflight[0].dropped) reached = 1'b1;
            else step(1'b1, 1'b0, 32'h0);
        end
        check("samecyc_setup", 32'(reached), 32'd1);
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 32'h0);
        check("samecyc_req", 32'(im_req), 32'd1);
        check("samecyc_addr", im_addr, 32'h0000_0200);
        wait_valid("samecyc_first", pc);
        check("samecyc_first_pc", pc, 32'h0000_0200);

        // Asynchronous reset mid-stream.
        lat = 3;
        drain_redirect(32'h0000_0400);
        reach_l2_o2("midrst_setup");
        rst = 1'b1;
        im_valid = 1'b0;
        #1;
        check("midrst_im_req", 32'(im_req), 32'd0);
        check("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_instr_pc", instr_pc, 32'd0);
        inflight.delete();
        q.delete();
        exp_fetch = 32'h0;
        @(posedge clk); #1 rst = 1'b0;
        lat = 1;
        step(1'b1, 1'b0, 32'h0);
        check("midrst_first_req", 32'(im_req), 32'd1);
        check("midrst_first_addr", im_addr, 32'h0);

        // Randomized traffic against the reference model.
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rdr = ($urandom_range(0, 99) < 5);
            ra  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step(($urandom_range(0, 3) != 0), rdr, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
